ringcounter_seq_ctrl: RTL and testbench
=======================================

// Module: ringcounter_seq_ctrl
// PURPOSE
// - Run/pause/stop sequencer for the one-hot LED ring counter.
// - Generates its own step enable from mclk through a programmable divider.
// - Owns the one-hot ring register, its direction and the optional end-bounce.
// - Sits between debounced front-panel pulses and the LED bank; replaces a free-running ring.
// PARAMETERS
// - WIDTH     8           ring length in bits; >= 3
// - DIV_W     24          divider counter width
// - DIV_BASE  12_500_000  mclk cycles per step at speed_sel=0; >= 8
// PORTS
// - mclk      in   1      system clock; everything is on its rising edge
// - rst       in   1      asynchronous active-high reset
// - start     in   1      1-cycle pulse: IDLE->RUN, PAUSE->RUN
// - stop      in   1      1-cycle pulse: RUN->PAUSE, PAUSE->IDLE
// - dir_tgl   in   1      1-cycle pulse: toggle shift direction
// - speed_sel in   2      step period = DIV_BASE >> speed_sel
// - bounce    in   1      1 = ping-pong at the ends, 0 = wrap
// - cnt       out  WIDTH  one-hot ring position
// - dir       out  1      0 = shift toward MSB, 1 = shift toward LSB
// - tick      out  1      high for the one cycle following each cnt step
// - state     out  2      00 IDLE, 01 RUN, 10 PAUSE
// BEHAVIOUR
// - Reset (async, rst=1): cnt=1, dir=0, tick=0, state=IDLE, div_cnt=0.
// - IDLE: cnt held at 1, div_cnt held at 0.
//   - start -> RUN.
//   - dir_tgl is still honoured in IDLE.
// - RUN: div_cnt increments each cycle.
//   - When div_cnt >= period-1, div_cnt clears to 0 and cnt steps on that edge.
//   - tick is registered: it is 1 for exactly the cycle after the step.
//   - First step occurs exactly period cycles after entering RUN from IDLE.
// - PAUSE: cnt, dir and div_cnt frozen.
//   - start -> RUN, resuming the divider from its frozen value.
//   - stop -> IDLE: cnt=1, div_cnt=0; dir is kept.
// - start and stop in the same cycle: stop wins.
// - Step rule, dir=0: cnt<<1; wrap from MSB gives 1.
// - Step rule, dir=1: cnt>>1; wrap from 1 gives MSB.
// - Bounce (bounce=1 in RUN), dir=0 with cnt at MSB: cnt becomes bit WIDTH-2 and dir flips to 1.
// - Bounce, dir=1 with cnt=1: cnt becomes 2 and dir flips to 0.
// - Recovery: cnt not one-hot (0 or multi-bit) at a step loads the home for the current dir.
//   - Home is 1 for dir=0, MSB for dir=1.
//   - Bounce does not apply to a recovery step.
// - Direction update: next dir = dir ^ dir_tgl ^ bounce_flip. The step in that cycle uses the old dir.
// - speed_sel is sampled every cycle with no latching.
//   - Lowering the period below div_cnt+1 causes a step on the next edge.
// - Every cnt update happens only on a step, or on IDLE entry/reset. No glitches.
// CONFIGURATION
// - RCTRL_BOUNCE_EN defined: bounce behaves as described above.
// - RCTRL_BOUNCE_EN undefined:
//   - bounce port is present but ignored; wrap only.
//   - bounce_flip is constantly 0.
//   - No bounce logic is synthesised.
// TESTING (DIV_BASE=8, WIDTH=8, RCTRL_BOUNCE_EN defined)
// - Reset mid-RUN with cnt=0x10 -> same cycle: cnt=0x01, dir=0, tick=0, state=00.
// - start, speed_sel=0, dir=0:
//   - first step 8 cycles later, cnt=0x02, tick on the next cycle.
//   - 8 steps later cnt=0x01, wrap.
// - speed_sel=3 (period 1), dir=1, start:
//   - cnt steps every cycle 0x01->0x80->0x40.
//   - tick held high continuously.
// - bounce=1, dir=0, run to 0x80:
//   - next step gives cnt=0x40, dir=1.
//   - at 0x01 the next step gives 0x02, dir=0.
// - RUN, stop at div_cnt=5 -> state=10, cnt frozen.
//   - start -> next step 2 cycles later.
//   - stop, stop -> IDLE, cnt=0x01.
// - start and stop same cycle from PAUSE -> IDLE.
// - dir_tgl on a step cycle -> that step uses old dir; the next step uses the new dir.

Source files
------------

// File: rtl/ringcounter_seq_ctrl.sv
// Run/pause/stop sequencer for a one-hot LED ring with a built-in step divider.
// Define RCTRL_BOUNCE_EN to enable ping-pong at the ring ends; otherwise wrap only.
module ringcounter_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 24,
  parameter int DIV_BASE = 12_500_000
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_tgl,
  input  logic [1:0]       speed_sel,
  input  logic             bounce,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             tick,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TWO = ONE << 1;
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH-1);
  localparam logic [WIDTH-1:0] SUB_MSB = ONE << (WIDTH-2);
  localparam logic [DIV_W-1:0] BASE = DIV_W'(DIV_BASE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0] period_m1;
  logic             cnt_onehot;
  logic             at_msb;
  logic             at_lsb;
  logic [WIDTH-1:0] step_cnt;
  logic             flip;
  logic             step;

  // speed_sel is live: the period follows it every cycle
  assign period_m1 = (BASE >> speed_sel) - DIV_W'(1);

  assign cnt_onehot = (cnt_q != '0) &&
    ((cnt_q & (cnt_q - ONE)) == '0);
  assign at_msb = cnt_q[WIDTH-1];
  assign at_lsb = cnt_q[0];

`ifndef RCTRL_BOUNCE_EN
  logic unused_bounce;
  assign unused_bounce = bounce;
`endif

  // next ring position and end-bounce flip for a step
  always_comb begin
    step_cnt = cnt_q;
    flip     = 1'b0;
    unique case (1'b1)
      !cnt_onehot: begin
        step_cnt = dir_q ? MSB : ONE;
      end
      cnt_onehot && !dir_q && at_msb: begin
`ifdef RCTRL_BOUNCE_EN
        if (bounce) begin
          step_cnt = SUB_MSB;
          flip     = 1'b1;
        end else begin
          step_cnt = ONE;
        end
`else
        step_cnt = ONE;
`endif
      end
      cnt_onehot && !dir_q && !at_msb: begin
        step_cnt = cnt_q << 1;
      end
      cnt_onehot && dir_q && at_lsb: begin
`ifdef RCTRL_BOUNCE_EN
        if (bounce) begin
          step_cnt = TWO;
          flip     = 1'b1;
        end else begin
          step_cnt = MSB;
        end
`else
        step_cnt = MSB;
`endif
      end
      cnt_onehot && dir_q && !at_lsb: begin
        step_cnt = cnt_q >> 1;
      end
      default: begin
        step_cnt = cnt_q;
      end
    endcase
  end

  // sequencer FSM, divider and ring next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    div_d   = div_q;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = ONE;
        div_d = '0;
        dir_d = dir_q ^ dir_tgl;
        if (start && !stop)
          state_d = S_RUN;
      end
      S_RUN: begin
        step  = (div_q >= period_m1);
        div_d = step ? '0 : div_q + DIV_W'(1);
        if (step)
          cnt_d = step_cnt;
        dir_d = dir_q ^ dir_tgl ^ (step & flip);
        if (stop)
          state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = ONE;
          div_d   = '0;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = ONE;
        div_d   = '0;
      end
    endcase
    tick_d = step;
  end

  // state registers
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= ONE;
      dir_q   <= 1'b0;
      div_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
    end
  end

  assign cnt   = cnt_q;
  assign dir   = dir_q;
  assign tick  = tick_q;
  assign state = state_q;

endmodule

// File: tb/tb_ringcounter_seq_ctrl.sv
// Directed bench for ringcounter_seq_ctrl at DIV_BASE=8, WIDTH=8.
// Bounce expectations follow whether RCTRL_BOUNCE_EN is defined.
module tb_ringcounter_seq_ctrl;

  logic       mclk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       dir_tgl;
  logic [1:0] speed_sel;
  logic       bounce;
  logic [7:0] cnt;
  logic       dir;
  logic       tick;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  ringcounter_seq_ctrl #(
    .WIDTH   (8),
    .DIV_W   (8),
    .DIV_BASE(8)
  ) dut (
    .mclk     (mclk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .dir_tgl  (dir_tgl),
    .speed_sel(speed_sel),
    .bounce   (bounce),
    .cnt      (cnt),
    .dir      (dir),
    .tick     (tick),
    .state    (state)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic p_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic p_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic p_tgl();
    dir_tgl = 1'b1;
    cyc(1);
    dir_tgl = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    dir_tgl   = 1'b0;
    speed_sel = 2'd0;
    bounce    = 1'b0;
    #1;
    check("rst_cnt", cnt, 8'h01);
    check("rst_dir", dir, 0);
    check("rst_tick", tick, 0);
    check("rst_state", state, 2'b00);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // period 8 run, first step and full wrap
    p_start();
    check("run_state", state, 2'b01);
    check("run_cnt0", cnt, 8'h01);
    cyc(7);
    check("pre_step", cnt, 8'h01);
    cyc(1);
    check("step1_cnt", cnt, 8'h02);
    check("step1_tick", tick, 1);
    cyc(1);
    check("tick_lo", tick, 0);
    cyc(47);
    check("step7", cnt, 8'h80);
    cyc(8);
    check("wrap", cnt, 8'h01);
    p_stop();
    check("pause", state, 2'b10);
    p_stop();
    check("idle", state, 2'b00);
    check("idle_cnt", cnt, 8'h01);

    // pause at div=5, resume continues the divider
    p_start();
    cyc(5);
    p_stop();
    check("ps_state", state, 2'b10);
    check("ps_cnt", cnt, 8'h01);
    p_tgl();
    check("ps_dir", dir, 0);
    cyc(2);
    check("ps_hold", cnt, 8'h01);
    p_start();
    check("res_state", state, 2'b01);
    cyc(1);
    check("res_c1", cnt, 8'h01);
    cyc(1);
    check("res_c2", cnt, 8'h02);
    check("res_tick", tick, 1);
    p_stop();
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    check("both_state", state, 2'b00);
    check("both_cnt", cnt, 8'h01);

    // period 1, dir=1
    p_tgl();
    check("idle_tgl", dir, 1);
    speed_sel = 2'd3;
    p_start();
    cyc(1);
    check("fast1", cnt, 8'h80);
    check("fast1_tk", tick, 1);
    cyc(1);
    check("fast2", cnt, 8'h40);
    cyc(1);
    check("fast3", cnt, 8'h20);
    check("fast3_tk", tick, 1);
    p_stop();
    p_stop();

    // end bounce
    p_tgl();
    check("b_dir0", dir, 0);
    bounce = 1'b1;
    p_start();
    cyc(7);
    check("b_msb", cnt, 8'h80);
    cyc(1);
`ifdef RCTRL_BOUNCE_EN
    check("b_top_cnt", cnt, 8'h40);
    check("b_top_dir", dir, 1);
`else
    check("b_top_cnt", cnt, 8'h01);
    check("b_top_dir", dir, 0);
`endif
    cyc(6);
`ifdef RCTRL_BOUNCE_EN
    check("b_lsb", cnt, 8'h01);
`else
    check("b_lsb", cnt, 8'h40);
`endif
    cyc(1);
`ifdef RCTRL_BOUNCE_EN
    check("b_bot_cnt", cnt, 8'h02);
`else
    check("b_bot_cnt", cnt, 8'h80);
`endif
    check("b_bot_dir", dir, 0);
    p_stop();
    p_stop();
    bounce = 1'b0;

    // dir_tgl on a step cycle
    p_start();
    cyc(1);
    check("tg_c1", cnt, 8'h02);
    dir_tgl = 1'b1;
    cyc(1);
    dir_tgl = 1'b0;
    check("tg_old", cnt, 8'h04);
    check("tg_dir", dir, 1);
    cyc(1);
    check("tg_new", cnt, 8'h02);
    p_stop();
    p_stop();
    p_tgl();

    // shrinking the period below div+1 steps at once
    speed_sel = 2'd0;
    p_start();
    cyc(5);
    check("sp_pre", cnt, 8'h01);
    speed_sel = 2'd2;
    cyc(1);
    check("sp_cnt", cnt, 8'h02);
    check("sp_tick", tick, 1);
    p_stop();
    p_stop();

    // async reset mid-run
    speed_sel = 2'd3;
    p_start();
    cyc(4);
    check("mr_cnt", cnt, 8'h10);
    rst = 1'b1;
    #1;
    check("mr_rcnt", cnt, 8'h01);
    check("mr_rdir", dir, 0);
    check("mr_rtick", tick, 0);
    check("mr_rst", state, 2'b00);
    cyc(2);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
